// File: rtl/esp_acc_pkg.sv
// Shared types for the chunked add accelerator: FSM states,
// DMA size codes, debug field widths and the DMA ctrl bundle.
package esp_acc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [2:0] DMA_SIZE_32 = 3'b010;
   localparam logic [2:0] DMA_SIZE_64 = 3'b011;

   localparam int DBG_PAD_W   = 16;
   localparam int DBG_CHUNK_W = 13;
   localparam int DBG_STATE_W = 3;

   typedef struct packed {
      logic [31:0] index;
      logic [31:0] length;
      logic [2:0]  size;
      logic [5:0]  user;
   } dma_ctrl_t;

   function automatic logic [2:0] dma_size(input int dw);
      return (dw == 64) ? DMA_SIZE_64 : DMA_SIZE_32;
   endfunction

endpackage

// File: rtl/esp_sync_fifo.sv
// Synchronous FIFO, flop storage, head read straight from flops.
// Ports: i_push/i_data in, i_pop in, o_head/o_full/o_empty out.
module esp_sync_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own;
   // the extra count bit separates full from empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/esp_acc_chunk_add.sv
// Chunked DMA add accelerator: reads LEN words in chunks of at
// most DEPTH, adds K, writes them to OUT_BASE + index.
// Ports: clk, rst (async, active-low), conf_info_reg0 (LEN),
// conf_info_reg1 (K), conf_done, acc_done, debug, and the
// dma_{read,write}_{ctrl,chnl}_* valid/ready/data interfaces.
// Build option ESP_ACC_CHUNK_ADD_SAT_EN: saturating add
// instead of wrapping add.
module esp_acc_chunk_add
   import esp_acc_pkg::*;
#(
   parameter int          DATA_W   = 64,
   parameter int          DEPTH    = 16,
   parameter logic [31:0] OUT_BASE = 32'd4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       conf_info_reg0,
   input  logic [31:0]       conf_info_reg1,
   input  logic              conf_done,
   output logic              acc_done,
   output logic [31:0]       debug,
   input  logic              dma_read_ctrl_ready,
   output logic              dma_read_ctrl_valid,
   output logic [31:0]       dma_read_ctrl_data_index,
   output logic [31:0]       dma_read_ctrl_data_length,
   output logic [2:0]        dma_read_ctrl_data_size,
   output logic [5:0]        dma_read_ctrl_data_user,
   output logic              dma_read_chnl_ready,
   input  logic              dma_read_chnl_valid,
   input  logic [DATA_W-1:0] dma_read_chnl_data,
   input  logic              dma_write_ctrl_ready,
   output logic              dma_write_ctrl_valid,
   output logic [31:0]       dma_write_ctrl_data_index,
   output logic [31:0]       dma_write_ctrl_data_length,
   output logic [2:0]        dma_write_ctrl_data_size,
   output logic [5:0]        dma_write_ctrl_data_user,
   input  logic              dma_write_chnl_ready,
   output logic              dma_write_chnl_valid,
   output logic [DATA_W-1:0] dma_write_chnl_data
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [31:0]            r_rem;
   logic [31:0]            r_idx;
   logic [31:0]            r_beats;
   logic [DATA_W-1:0]      r_k;
   logic [DBG_CHUNK_W-1:0] r_chunks;
   logic                   r_acc_done;
   logic                   r_rd_cvalid;
   logic                   r_wr_cvalid;
   dma_ctrl_t              r_rd_ctrl;
   dma_ctrl_t              r_wr_ctrl;

   logic [31:0]       w_cl;
   logic              w_rd_chs;
   logic              w_wr_chs;
   logic              w_rd_hs;
   logic              w_wr_hs;
   logic              w_rd_last;
   logic              w_wr_last;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_head;

   assign w_cl = (r_rem > 32'(DEPTH)) ? 32'(DEPTH) : r_rem;

`ifdef ESP_ACC_CHUNK_ADD_SAT_EN
   logic [DATA_W:0] w_add;
   assign w_add = {1'b0, dma_read_chnl_data} + {1'b0, r_k};
   assign w_sum = w_add[DATA_W] ? '1 : w_add[DATA_W-1:0];
`else
   assign w_sum = dma_read_chnl_data + r_k;
`endif

   assign dma_read_chnl_ready = (r_state == RD_DATA)
                              && (r_beats < w_cl)
                              && !w_fifo_full;
   assign dma_write_chnl_valid = (r_state == WR_DATA)
                               && !w_fifo_empty
                               && (r_beats < w_cl);

   assign w_rd_hs   = dma_read_chnl_valid && dma_read_chnl_ready;
   assign w_wr_hs   = dma_write_chnl_valid && dma_write_chnl_ready;
   assign w_rd_last = w_rd_hs && (r_beats == w_cl - 32'd1);
   assign w_wr_last = w_wr_hs && (r_beats == w_cl - 32'd1);
   assign w_rd_chs  = r_rd_cvalid && dma_read_ctrl_ready;
   assign w_wr_chs  = r_wr_cvalid && dma_write_ctrl_ready;

   esp_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rd_hs),
      .i_data  (w_sum),
      .i_pop   (w_wr_hs),
      .o_head  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (conf_done) begin
               w_state_nxt = (conf_info_reg0 == '0) ? DONE : RD_REQ;
            end
         end
         RD_REQ: begin
            if (w_rd_chs) w_state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (w_rd_last) w_state_nxt = WR_REQ;
         end
         WR_REQ: begin
            if (w_wr_chs) w_state_nxt = WR_DATA;
         end
         WR_DATA: begin
            if (w_wr_last) begin
               w_state_nxt = (r_rem > w_cl) ? RD_REQ : DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ctrl valid rises the cycle after entering a REQ state and
   // falls right after its handshake; fields load with valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc_done  <= 1'b0;
         r_rd_cvalid <= 1'b0;
         r_wr_cvalid <= 1'b0;
         r_rd_ctrl   <= '0;
         r_wr_ctrl   <= '0;
      end else begin
         r_acc_done  <= (r_state == DONE);
         r_rd_cvalid <= (r_state == RD_REQ) && !w_rd_chs;
         r_wr_cvalid <= (r_state == WR_REQ) && !w_wr_chs;
         if ((r_state == RD_REQ) && !r_rd_cvalid) begin
            r_rd_ctrl.index  <= r_idx;
            r_rd_ctrl.length <= w_cl;
            r_rd_ctrl.size   <= dma_size(DATA_W);
            r_rd_ctrl.user   <= 6'd0;
         end
         if ((r_state == WR_REQ) && !r_wr_cvalid) begin
            r_wr_ctrl.index  <= OUT_BASE + r_idx;
            r_wr_ctrl.length <= w_cl;
            r_wr_ctrl.size   <= dma_size(DATA_W);
            r_wr_ctrl.user   <= 6'd0;
         end
      end
   end

   // One beat counter serves both data phases; it is zero
   // whenever a data phase starts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem    <= '0;
         r_idx    <= '0;
         r_beats  <= '0;
         r_k      <= '0;
         r_chunks <= '0;
      end else begin
         if ((r_state == IDLE) && conf_done) begin
            r_rem    <= conf_info_reg0;
            r_k      <= DATA_W'(conf_info_reg1);
            r_idx    <= '0;
            r_beats  <= '0;
            r_chunks <= '0;
         end
         if (w_rd_hs) begin
            r_beats <= w_rd_last ? 32'd0 : r_beats + 32'd1;
         end
         if (w_wr_hs) begin
            r_beats <= w_wr_last ? 32'd0 : r_beats + 32'd1;
         end
         if (w_wr_last) begin
            r_idx    <= r_idx + w_cl;
            r_rem    <= r_rem - w_cl;
            r_chunks <= r_chunks + DBG_CHUNK_W'(1);
         end
      end
   end

   assign acc_done = r_acc_done;
   assign debug    = {{DBG_PAD_W{1'b0}}, r_chunks, r_state};

   assign dma_read_ctrl_valid       = r_rd_cvalid;
   assign dma_read_ctrl_data_index  = r_rd_ctrl.index;
   assign dma_read_ctrl_data_length = r_rd_ctrl.length;
   assign dma_read_ctrl_data_size   = r_rd_ctrl.size;
   assign dma_read_ctrl_data_user   = r_rd_ctrl.user;

   assign dma_write_ctrl_valid       = r_wr_cvalid;
   assign dma_write_ctrl_data_index  = r_wr_ctrl.index;
   assign dma_write_ctrl_data_length = r_wr_ctrl.length;
   assign dma_write_ctrl_data_size   = r_wr_ctrl.size;
   assign dma_write_ctrl_data_user   = r_wr_ctrl.user;

   assign dma_write_chnl_data = w_head;

endmodule

// File: doc/esp_acc_chunk_add.md
# esp_acc_chunk_add

Parametrised successor to the single-burst 64-bit DMA test accelerator. It streams a runtime-configured number of words from accelerator memory through an internal FIFO, adds a runtime constant (wrapping or saturating), and writes results to an output region. Transfers are split into chunks of at most `DEPTH` words, so arbitrarily long transfers work. It sits behind the ESP accelerator socket and is driven by the standard DMA read/write control and channel interfaces.

## Interface
- `DATA_W`, 64: DMA channel word width. Legal values are 32 and 64.
- `DEPTH`, 16: FIFO depth and maximum chunk length in words. Must be a power of two, ≥2.
- `OUT_BASE`, 32'd4096: word index of the output region.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `conf_info_reg0`  in  32  total transfer length in words (LEN).
- `conf_info_reg1`  in  32  addend K; the low `DATA_W` bits are used, zero-extended.
- `conf_done`  in  1  start; sampled only in IDLE.
- `acc_done`  out  1  one-cycle completion pulse.
- `debug`  out  32  {16'd0, chunk count[12:0], state[2:0]}.
- `dma_read_ctrl_*`, `dma_write_ctrl_*`: valid/ready plus index 32, length 32, size 3, user 6.
- `dma_read_chnl_*`, `dma_write_chnl_*`: valid/ready plus data `DATA_W`.

## Operation
- Registers LEN and K are latched on `conf_done` in IDLE. REM = LEN, IDX = 0. Chunk length CL = min(DEPTH, REM).
- State sequence:
  - IDLE → RD_REQ on `conf_done`, or → DONE if LEN == 0.
  - RD_REQ → RD_DATA on read ctrl handshake.
  - RD_DATA → WR_REQ after CL beats have been accepted.
  - WR_REQ → WR_DATA on write ctrl handshake.
  - WR_DATA → RD_REQ after CL beats are written and REM > 0; otherwise → DONE.
  - DONE → IDLE.
- Read ctrl fields: index = IDX, length = CL, size = 3'b011 if `DATA_W` is 64 else 3'b010, user = 0.
- Write ctrl fields: index = `OUT_BASE` + IDX, with length, size and user as for read.
- Read data: each accepted beat D pushes D + K into the FIFO, computed at `DATA_W` bits.
- Write data: the FIFO head is presented; it pops on write channel handshake.
- At the end of WR_DATA: IDX += CL, REM -= CL.
- Chunk count increments once per completed chunk and clears in IDLE on start.

## Timing
- Reset values: all valid, ready and `acc_done` outputs are 0; all index, length, size, user and data outputs are 0; state is IDLE; FIFO is empty.
- Reset mid-operation aborts immediately. No partial DMA completion is attempted.
- Ctrl valid rises one cycle after state entry and drops the cycle after valid&&ready. Fields are stable while valid is high.
- `dma_read_chnl_ready` is high in RD_DATA while beats accepted < CL and the FIFO is not full. It drops in the same cycle the CL-th beat is accepted.
- `dma_write_chnl_valid` is high in WR_DATA while the FIFO is not empty and beats sent < CL.
  - Data is registered and stable while valid && !ready.
  - Back-to-back handshakes sustain 1 beat/cycle.
- Channel handshakes are counted only in their own state; ctrl and channel handshakes may coincide.
- `conf_done` outside IDLE is ignored.
- `acc_done` pulses for exactly one cycle, on the cycle after DONE is entered.
- Latency for LEN = DEPTH with always-ready DMA: ≤ 2·DEPTH + 8 cycles from `conf_done` to `acc_done`.

## Configuration
- `ESP_ACC_CHUNK_ADD_SAT_EN` defined: the addition saturates, so an unsigned overflow yields all ones at `DATA_W` bits.
- Undefined: the addition wraps modulo 2^`DATA_W`.

## Structure
- Package `esp_acc_pkg`:
  - state enum (IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE)
  - DMA size codes `DMA_SIZE_32` = 3'b010 and `DMA_SIZE_64` = 3'b011
  - `debug` field widths
- Sub-module `esp_sync_fifo` (`DATA_W`, `DEPTH`): push/pop, full/empty, registered head, pointer wrap via a `$clog2(DEPTH)+1`-bit count.

## Test plan
- DEPTH = 16, LEN = 16, K = 100, input i → one read (index 0, length 16), one write (index 4096, length 16), data i+100, one `acc_done` pulse.
- LEN = 40 → read/write chunks of 16, 16, 8 at indices 0, 16, 32 (writes at 4096 + same offsets); chunk count ends at 3.
- LEN = 0 → no DMA valids; `acc_done` pulses 2 cycles after `conf_done`.
- Random ready/valid throttling on all four interfaces, LEN = 37 → output equals input + K in order with no duplicates or drops.
- Input 64'hFFFF_FFFF_FFFF_FFF0, K = 32 → output 64'h10 without the macro, 64'hFFFF_FFFF_FFFF_FFFF with `ESP_ACC_CHUNK_ADD_SAT_EN`.
- `rst` asserted mid-WR_DATA → all outputs 0 next edge; a fresh `conf_done` with LEN = 4 completes correctly.
